// File: rtl/gcd_seq_pkg.sv
// Shared encodings and sizing helpers for the GCD test sequencer and its golden engine.
// Pure declarations: no logic, no latency, no flow control.
package gcd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPURST,
        S_START,
        S_WAIT,
        S_VERDICT
    } seq_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RUN,
        R_DONE
    } ref_state_t;

    localparam int DEF_TIMEOUT = 4096;

    // Bits needed to hold a count of 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gcd_ref_engine.sv
// Iterative binary (Stein) GCD golden model; done within 2*WIDTH+2 cycles of start.
// No backpressure: a start pulse restarts the engine, done/gcd hold until the next start.
module gcd_ref_engine
    import gcd_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] gcd
);

    localparam int K_W = cnt_w(WIDTH);

    ref_state_t       state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [K_W-1:0]   k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= R_IDLE;
            x     <= '0;
            y     <= '0;
            k     <= '0;
            done  <= 1'b0;
            gcd   <= '0;
        end else if (start) begin
            x     <= a;
            y     <= b;
            k     <= '0;
            done  <= 1'b0;
            state <= R_RUN;
        end else begin
            case (state)
                R_RUN: begin
                    // Each step removes at least one bit from x or y, bounding the run.
                    if (x == '0) begin
                        gcd   <= y << k;
                        done  <= 1'b1;
                        state <= R_DONE;
                    end else if (y == '0) begin
                        gcd   <= x << k;
                        done  <= 1'b1;
                        state <= R_DONE;
                    end else if (!x[0] && !y[0]) begin
                        x <= x >> 1;
                        y <= y >> 1;
                        k <= k + 1'b1;
                    end else if (!x[0]) begin
                        x <= x >> 1;
                    end else if (!y[0]) begin
                        y <= y >> 1;
                    end else if (x >= y) begin
                        x <= (x - y) >> 1;
                    end else begin
                        y <= (y - x) >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gcd_test_sequencer.sv
// Runs one CPU GCD job per accepted pair (reset, start, watch result) and judges it against a golden engine.
// vec_ready only in IDLE, no queuing; optional first-fail capture via GCD_SEQ_FAIL_CAPTURE_EN.
module gcd_test_sequencer
    import gcd_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RST_CYCLES = 2,
    parameter int START_CYC  = 6,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    output logic             cpu_rst_n,
    output logic             calc_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             res_valid,
    output logic             res_pass,
    output logic [WIDTH-1:0] res_exp,
    output logic [WIDTH-1:0] res_got,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
`ifdef GCD_SEQ_FAIL_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_got,
    output logic             fail_seen
`endif
);

    localparam int PH_W = cnt_w((RST_CYCLES > START_CYC) ? RST_CYCLES : START_CYC);
    localparam int TO_W = cnt_w(TIMEOUT);
    localparam int ST_W = cnt_w(STABLE_CYC);

    seq_state_t       state;
    logic [PH_W-1:0]  phase;
    logic [TO_W-1:0]  to_cnt;
    logic [ST_W-1:0]  stable_cnt;

    logic             ref_start;
    logic             ref_done;
    logic [WIDTH-1:0] ref_gcd;

    logic             match;
    logic [ST_W-1:0]  stable_nxt;
    logic [TO_W-1:0]  to_nxt;
    logic             hit_stable;
    logic             hit_to;

    assign ref_start  = (state == S_IDLE) && vec_valid && vec_ready;
    // Stability only counts once the golden value is final.
    assign match      = ref_done && (gcd_result == ref_gcd);
    assign stable_nxt = match ? stable_cnt + 1'b1 : '0;
    assign to_nxt     = to_cnt + 1'b1;
    assign hit_stable = (stable_nxt == ST_W'(STABLE_CYC));
    assign hit_to     = (to_nxt == TO_W'(TIMEOUT));

    gcd_ref_engine #(.WIDTH(WIDTH)) u_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ref_start),
        .a     (vec_a),
        .b     (vec_b),
        .done  (ref_done),
        .gcd   (ref_gcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= '0;
            to_cnt     <= '0;
            stable_cnt <= '0;
            vec_ready  <= 1'b0;
            cpu_rst_n  <= 1'b0;
            calc_start <= 1'b0;
            gcd_a      <= '0;
            gcd_b      <= '0;
            res_valid  <= 1'b0;
            res_pass   <= 1'b0;
            res_exp    <= '0;
            res_got    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            busy       <= 1'b0;
`ifdef GCD_SEQ_FAIL_CAPTURE_EN
            fail_a     <= '0;
            fail_b     <= '0;
            fail_got   <= '0;
            fail_seen  <= 1'b0;
`endif
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vec_valid && vec_ready) begin
                        gcd_a     <= vec_a;
                        gcd_b     <= vec_b;
                        vec_ready <= 1'b0;
                        busy      <= 1'b1;
                        phase     <= '0;
                        state     <= S_CPURST;
                    end else begin
                        vec_ready <= 1'b1;
                    end
                end
                S_CPURST: begin
                    if (phase == PH_W'(RST_CYCLES - 1)) begin
                        phase      <= '0;
                        cpu_rst_n  <= 1'b1;
                        calc_start <= 1'b1;
                        state      <= S_START;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_START: begin
                    if (phase == PH_W'(START_CYC - 1)) begin
                        phase      <= '0;
                        calc_start <= 1'b0;
                        to_cnt     <= '0;
                        stable_cnt <= '0;
                        state      <= S_WAIT;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_WAIT: begin
                    to_cnt     <= to_nxt;
                    stable_cnt <= stable_nxt;
                    // Pass is checked first so a simultaneous timeout still passes.
                    if (hit_stable || hit_to) begin
                        res_valid <= 1'b1;
                        res_pass  <= hit_stable;
                        res_got   <= gcd_result;
                        res_exp   <= ref_gcd;
                        cpu_rst_n <= 1'b0;
                        state     <= S_VERDICT;
                        if (hit_stable) begin
                            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                        end else begin
                            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
`ifdef GCD_SEQ_FAIL_CAPTURE_EN
                            if (!fail_seen) begin
                                fail_a    <= gcd_a;
                                fail_b    <= gcd_b;
                                fail_got  <= gcd_result;
                                fail_seen <= 1'b1;
                            end
`endif
                        end
                    end
                end
                S_VERDICT: begin
                    busy      <= 1'b0;
                    vec_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_test_sequencer.sv
// Directed bench for gcd_test_sequencer with a behavioural CPU model (correct, stuck-at-1, glitching).
module tb_gcd_test_sequencer;

    localparam int W       = 32;
    localparam int STABLE  = 4;
    localparam int TMO     = 64;
    localparam int CW      = 2;
    localparam int CPU_LAT = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vec_valid;
    logic          vec_ready;
    logic [W-1:0]  vec_a;
    logic [W-1:0]  vec_b;
    logic          cpu_rst_n;
    logic          calc_start;
    logic [W-1:0]  gcd_a;
    logic [W-1:0]  gcd_b;
    logic [W-1:0]  gcd_result;
    logic          res_valid;
    logic          res_pass;
    logic [W-1:0]  res_exp;
    logic [W-1:0]  res_got;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          busy;
`ifdef GCD_SEQ_FAIL_CAPTURE_EN
    logic [W-1:0]  fail_a;
    logic [W-1:0]  fail_b;
    logic [W-1:0]  fail_got;
    logic          fail_seen;
`endif

    gcd_test_sequencer #(
        .WIDTH(W), .RST_CYCLES(2), .START_CYC(6), .STABLE_CYC(STABLE),
        .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_a      (vec_a),
        .vec_b      (vec_b),
        .cpu_rst_n  (cpu_rst_n),
        .calc_start (calc_start),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_result (gcd_result),
        .res_valid  (res_valid),
        .res_pass   (res_pass),
        .res_exp    (res_exp),
        .res_got    (res_got),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .busy       (busy)
`ifdef GCD_SEQ_FAIL_CAPTURE_EN
        ,
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_got   (fail_got),
        .fail_seen  (fail_seen)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // CPU model: mode 0 correct after CPU_LAT, 1 always returns 1, 2 correct with a one-cycle glitch.
    int           cpu_mode  = 0;
    logic [W-1:0] cpu_exp   = '0;
    int           cpu_cnt   = 0;
    int           glitch_cyc = 0;

    initial begin
        gcd_result = '0;
        forever begin
            @(negedge clk);
            if (!cpu_rst_n) begin
                cpu_cnt    = 0;
                gcd_result = '0;
            end else begin
                cpu_cnt = cpu_cnt + 1;
                case (cpu_mode)
                    1: gcd_result = 32'd1;
                    2: begin
                        if (cpu_cnt == CPU_LAT + 2) begin
                            gcd_result = cpu_exp + 32'd1;
                            glitch_cyc = cyc + 1;
                        end else begin
                            gcd_result = (cpu_cnt >= CPU_LAT) ? cpu_exp : '0;
                        end
                    end
                    default: gcd_result = (cpu_cnt >= CPU_LAT) ? cpu_exp : '0;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                           output int n_valid, output logic p, output logic [W-1:0] e,
                           output logic [W-1:0] g, output int wc, output logic viol);
        int guard;
        bit seen;
        cpu_mode = mode;
        cpu_exp  = euclid(a, b);
        n_valid = 0; p = 1'b0; e = '0; g = '0; wc = 0; viol = 1'b0;
        guard = 0;
        while (!vec_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        vec_a = a;
        vec_b = b;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        seen  = 1'b0;
        guard = 0;
        while (guard < TMO + 100) begin
            if (res_valid) begin
                n_valid++;
                p = res_pass; e = res_exp; g = res_got;
                seen = 1'b1;
            end
            if (seen && !busy) break;
            if (vec_ready) viol = 1'b1;
            if (cpu_rst_n && !calc_start && busy) wc++;
            @(negedge clk);
            guard++;
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           mode;
        logic         pass;
        logic [W-1:0] exp;
        logic [W-1:0] got;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int nv, wc, exp_pc, exp_fc, nrv, guard;
        logic p, viol;
        logic [W-1:0] e, g;

        tbl[0] = '{a: 32'd15,         b: 32'd10,  mode: 0, pass: 1'b1, exp: 32'd5,  got: 32'd5};
        tbl[1] = '{a: 32'd12,         b: 32'd8,   mode: 1, pass: 1'b0, exp: 32'd4,  got: 32'd1};
        tbl[2] = '{a: 32'd48,         b: 32'd18,  mode: 0, pass: 1'b1, exp: 32'd6,  got: 32'd6};
        tbl[3] = '{a: 32'd0,          b: 32'd7,   mode: 0, pass: 1'b1, exp: 32'd7,  got: 32'd7};
        tbl[4] = '{a: 32'd0,          b: 32'd0,   mode: 0, pass: 1'b1, exp: 32'd0,  got: 32'd0};
        tbl[5] = '{a: 32'hFFFF_FFFE,  b: 32'd6,   mode: 0, pass: 1'b1, exp: 32'd2,  got: 32'd2};
        tbl[6] = '{a: 32'd9,          b: 32'd6,   mode: 1, pass: 1'b0, exp: 32'd3,  got: 32'd1};

        rst_n = 1'b0; vec_valid = 1'b0; vec_a = '0; vec_b = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst_n", W'(cpu_rst_n), 32'd0);
        check("rst_vec_ready", W'(vec_ready), 32'd0);
        check("rst_busy", W'(busy), 32'd0);
        check("rst_res_valid", W'(res_valid), 32'd0);
        check("rst_calc_start", W'(calc_start), 32'd0);
        check("rst_res_exp", res_exp, 32'd0);
        check("rst_pass_cnt", W'(pass_cnt), 32'd0);
        check("rst_fail_cnt", W'(fail_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_vec_ready", W'(vec_ready), 32'd1);

        exp_pc = 0; exp_fc = 0;
        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].a, tbl[i].b, tbl[i].mode, nv, p, e, g, wc, viol);
            if (tbl[i].pass) exp_pc = (exp_pc < 3) ? exp_pc + 1 : 3;
            else             exp_fc = (exp_fc < 3) ? exp_fc + 1 : 3;
            check($sformatf("tbl%0d_valid_count", i), W'(nv), 32'd1);
            check($sformatf("tbl%0d_pass", i), W'(p), W'(tbl[i].pass));
            check($sformatf("tbl%0d_exp", i), e, tbl[i].exp);
            check($sformatf("tbl%0d_got", i), g, tbl[i].got);
            check($sformatf("tbl%0d_ready_low", i), W'(viol), 32'd0);
            check($sformatf("tbl%0d_pass_cnt", i), W'(pass_cnt), W'(exp_pc));
            check($sformatf("tbl%0d_fail_cnt", i), W'(fail_cnt), W'(exp_fc));
            check($sformatf("tbl%0d_exp_hold", i), res_exp, tbl[i].exp);
            if (!tbl[i].pass) check($sformatf("tbl%0d_wait_cycles", i), W'(wc), W'(TMO));
        end
`ifdef GCD_SEQ_FAIL_CAPTURE_EN
        check("cap_seen", W'(fail_seen), 32'd1);
        check("cap_a", fail_a, 32'd12);
        check("cap_b", fail_b, 32'd8);
        check("cap_got", fail_got, 32'd1);
`endif

        // One-cycle wrong value mid-stabilisation restarts the stable count.
        run_job(32'd21, 32'd14, 2, nv, p, e, g, wc, viol);
        check("glitch_valid_count", W'(nv), 32'd1);
        check("glitch_pass", W'(p), 32'd1);
        check("glitch_exp", e, 32'd7);
        check("glitch_delay", W'(cyc - 1 - glitch_cyc), W'(STABLE));

        // Asynchronous reset in WAIT aborts the job without a verdict.
        cpu_mode = 1;
        cpu_exp  = 32'd4;
        guard = 0;
        while (!vec_ready && guard < 50) begin @(negedge clk); guard++; end
        vec_a = 32'd20; vec_b = 32'd16; vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        guard = 0;
        while (!(cpu_rst_n && !calc_start) && guard < 50) begin @(negedge clk); guard++; end
        check("abort_reached_wait", W'(cpu_rst_n && !calc_start && busy), 32'd1);
        repeat (3) @(negedge clk);
        check("abort_pre_pass_cnt", W'(pass_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), 32'd0);
        check("abort_cpu_rst_n", W'(cpu_rst_n), 32'd0);
        check("abort_pass_cnt", W'(pass_cnt), 32'd0);
        check("abort_fail_cnt", W'(fail_cnt), 32'd0);
`ifdef GCD_SEQ_FAIL_CAPTURE_EN
        check("abort_cap_seen", W'(fail_seen), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        nrv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) nrv++;
        end
        check("abort_no_verdict", W'(nrv), 32'd0);
        check("abort_idle_ready", W'(vec_ready), 32'd1);

        // Pass counter saturates at 3 with a 2-bit width.
        for (int i = 0; i < 5; i++) begin
            run_job(32'(6 * (i + 1)), 32'(4 * (i + 1)), 0, nv, p, e, g, wc, viol);
            check($sformatf("sat%0d_exp", i), e, 32'(2 * (i + 1)));
            check($sformatf("sat%0d_pass_cnt", i), W'(pass_cnt), W'((i + 1 < 3) ? i + 1 : 3));
            check($sformatf("sat%0d_fail_cnt", i), W'(fail_cnt), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog");
    end

endmodule
